// File: rtl/unpacked_array_regbank_pkg.sv
// Shared op encodings and reset-value arithmetic for the unpacked-array register bank.
package arr_regbank_pkg;

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_ROT_UP = 2'b01;
  localparam logic [1:0] OP_ROT_DN = 2'b10;
  localparam logic [1:0] OP_RELOAD = 2'b11;

  // Reset value of entry i: base + i*step in 64-bit signed, wrapped to width bits.
  function automatic longint reset_val(longint base, longint step, int i, int width);
    longint v;
    v = base + longint'(i) * step;
    if (width < 64) begin
      v = v & ((longint'(1) <<< width) - 1);
    end
    return v;
  endfunction

endpackage

// File: rtl/unpacked_array_regbank_entry.sv
// One bank entry: a WIDTH-bit register with its own reset constant and a load/reload mux.
module arr_regbank_entry #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reload,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reload beats load; otherwise take the next value only when the top asks for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (reload) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/unpacked_array_regbank.sv
// Register bank kept as an unpacked array: indexed write, registered read, rotate, reload.
module unpacked_array_regbank
  import arr_regbank_pkg::*;
#(
  parameter int     WIDTH      = 32,
  parameter int     DEPTH      = 4,
  parameter longint RESET_BASE = 13,
  parameter longint RESET_STEP = -1,
  localparam int    IDX_W      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [1:0]             op,
  input  logic                   rd_en,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   err,
  output logic [DEPTH*WIDTH-1:0] entries_flat
);

  logic [WIDTH-1:0] ent [DEPTH];
  logic             reload;
  logic             rotating;
  logic             wr_bad;
  logic             rd_ok;
  logic             rd_bad;

  assign reload   = (op == OP_RELOAD);
  assign rotating = (op == OP_ROT_UP) || (op == OP_ROT_DN);
  assign wr_bad   = wr_en && (int'(wr_idx) >= DEPTH);
  assign rd_ok    = (int'(rd_idx) < DEPTH);
  assign rd_bad   = rd_en && !rd_ok;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    localparam int               UP = (i + DEPTH - 1) % DEPTH;
    localparam int               DN = (i + 1) % DEPTH;
    localparam logic [WIDTH-1:0] RV = WIDTH'(reset_val(RESET_BASE, RESET_STEP, i, WIDTH));

    logic             hit;
    logic [WIDTH-1:0] rot;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    // Value this slot holds after the rotate; a same-edge write then overrides it.
    always_comb begin
      rot = ent[i];
      if (op == OP_ROT_UP) begin
        rot = ent[UP];
      end else if (op == OP_ROT_DN) begin
        rot = ent[DN];
      end
    end

    assign hit = wr_en && (wr_idx == IDX_W'(i));
    assign d   = hit ? wr_data : rot;

    arr_regbank_entry #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RV)
    ) u_entry (
      .clk    (clk),
      .rst_n  (rst_n),
      .reload (reload),
      .load   (rotating || hit),
      .d      (d),
      .q      (q)
    );

    assign ent[i] = q;
    assign entries_flat[i*WIDTH +: WIDTH] = q;
  end

  // Registered read of the pre-update array plus one-cycle range-fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      err      <= wr_bad || rd_bad;
      if (rd_en) begin
        rd_data <= rd_ok ? ent[rd_idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_unpacked_array_regbank.sv
// Bench for unpacked_array_regbank: a default instance and a DEPTH=5, WIDTH=8 wrap instance.
module tb_unpacked_array_regbank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en_s  [2];
  logic        rd_en_s  [2];
  logic [2:0]  wr_idx_s [2];
  logic [2:0]  rd_idx_s [2];
  logic [31:0] wr_data_s[2];
  logic [1:0]  op_s     [2];

  logic [31:0]  rd_data0;
  logic         rd_valid0, err0;
  logic [127:0] flat0;
  logic [7:0]   rd_data1;
  logic         rd_valid1, err1;
  logic [39:0]  flat1;

  int errors = 0;
  int checks = 0;

  // Reference model: plain arrays of entry values, per-instance parameters.
  longint      base_m[2] = '{13, 0};
  longint      step_m[2] = '{-1, -1};
  int          dep   [2] = '{4, 5};
  logic [31:0] mask  [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
  logic [31:0] m     [2][5];
  logic [31:0] exp_rd [2];
  logic        exp_vld[2];
  logic        exp_err[2];

  unpacked_array_regbank u_dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en_s[0]),
    .wr_idx       (wr_idx_s[0][1:0]),
    .wr_data      (wr_data_s[0]),
    .op           (op_s[0]),
    .rd_en        (rd_en_s[0]),
    .rd_idx       (rd_idx_s[0][1:0]),
    .rd_data      (rd_data0),
    .rd_valid     (rd_valid0),
    .err          (err0),
    .entries_flat (flat0)
  );

  unpacked_array_regbank #(
    .WIDTH      (8),
    .DEPTH      (5),
    .RESET_BASE (0),
    .RESET_STEP (-1)
  ) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en_s[1]),
    .wr_idx       (wr_idx_s[1]),
    .wr_data      (wr_data_s[1][7:0]),
    .op           (op_s[1]),
    .rd_en        (rd_en_s[1]),
    .rd_idx       (rd_idx_s[1]),
    .rd_data      (rd_data1),
    .rd_valid     (rd_valid1),
    .err          (err1),
    .entries_flat (flat1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reload_entries(input int k);
    for (int i = 0; i < dep[k]; i++) begin
      m[k][i] = 32'(base_m[k] + longint'(i) * step_m[k]) & mask[k];
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      model_reload_entries(k);
      exp_rd[k]  = '0;
      exp_vld[k] = 1'b0;
      exp_err[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [31:0] old [5];
    int d;
    for (int k = 0; k < 2; k++) begin
      d = dep[k];
      for (int i = 0; i < 5; i++) old[i] = m[k][i];
      exp_err[k] = (wr_en_s[k] && int'(wr_idx_s[k]) >= d) ||
                   (rd_en_s[k] && int'(rd_idx_s[k]) >= d);
      if (rd_en_s[k]) begin
        exp_vld[k] = 1'b1;
        exp_rd[k]  = (int'(rd_idx_s[k]) < d) ? old[rd_idx_s[k]] : 32'd0;
      end else begin
        exp_vld[k] = 1'b0;
      end
      if (op_s[k] == 2'b11) begin
        model_reload_entries(k);
      end else begin
        if (op_s[k] == 2'b01) for (int i = 0; i < d; i++) m[k][i] = old[(i + d - 1) % d];
        if (op_s[k] == 2'b10) for (int i = 0; i < d; i++) m[k][i] = old[(i + 1) % d];
        if (wr_en_s[k] && int'(wr_idx_s[k]) < d) m[k][wr_idx_s[k]] = wr_data_s[k] & mask[k];
      end
    end
  endtask

  task automatic check_all();
    logic [127:0] e0 = '0;
    logic [127:0] e1 = '0;
    for (int i = 0; i < 4; i++) e0[i*32 +: 32] = m[0][i];
    for (int i = 0; i < 5; i++) e1[i*8 +: 8] = m[1][i][7:0];
    check("flat0", flat0, e0);
    check("rd_data0", 128'(rd_data0), 128'(exp_rd[0]));
    check("rd_valid0", 128'(rd_valid0), 128'(exp_vld[0]));
    check("err0", 128'(err0), 128'(exp_err[0]));
    check("flat1", 128'(flat1), e1);
    check("rd_data1", 128'(rd_data1), 128'(exp_rd[1][7:0]));
    check("rd_valid1", 128'(rd_valid1), 128'(exp_vld[1]));
    check("err1", 128'(err1), 128'(exp_err[1]));
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      wr_en_s[k]   = 1'b0;
      rd_en_s[k]   = 1'b0;
      wr_idx_s[k]  = '0;
      rd_idx_s[k]  = '0;
      wr_data_s[k] = '0;
      op_s[k]      = 2'b00;
    end
  endtask

  task automatic rand_inputs();
    int r;
    for (int k = 0; k < 2; k++) begin
      wr_en_s[k]   = 1'($urandom_range(0, 1));
      rd_en_s[k]   = 1'($urandom_range(0, 1));
      wr_idx_s[k]  = 3'((k == 0) ? $urandom_range(0, 3) : $urandom_range(0, 7));
      rd_idx_s[k]  = 3'((k == 0) ? $urandom_range(0, 3) : $urandom_range(0, 7));
      wr_data_s[k] = $urandom;
      r = int'($urandom_range(0, 7));
      op_s[k] = (r < 4) ? 2'b00 : 2'(r - 4);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    model_reset();
    check_all();
    check("reset_flat0_const", flat0, 128'h0000000a_0000000b_0000000c_0000000d);
    check("reset_flat1_wrap", 128'(flat1), 128'hfc_fd_fe_ff_00);
    @(negedge clk);
    rst_n = 1'b1;

    // Read, then read-during-write returns the old value, then the new one.
    rd_en_s[0] = 1'b1; rd_idx_s[0] = 3'd2;
    tick();
    check("rd_idx2", 128'(rd_data0), 128'd11);
    wr_en_s[0] = 1'b1; wr_idx_s[0] = 3'd2; wr_data_s[0] = 32'hDEAD;
    rd_en_s[0] = 1'b1; rd_idx_s[0] = 3'd2;
    tick();
    check("rd_old_value", 128'(rd_data0), 128'd11);
    rd_en_s[0] = 1'b1; rd_idx_s[0] = 3'd2;
    tick();
    check("rd_new_value", 128'(rd_data0), 128'hDEAD);

    // Rotate up once from reset values, then down twice.
    op_s[0] = 2'b11;
    tick();
    op_s[0] = 2'b01;
    tick();
    check("rot_up", flat0, 128'h0000000b_0000000c_0000000d_0000000a);
    op_s[0] = 2'b10;
    tick();
    op_s[0] = 2'b10;
    tick();
    check("rot_dn2", flat0, 128'h0000000d_0000000a_0000000b_0000000c);

    // Rotate with a coinciding write.
    op_s[0] = 2'b11;
    tick();
    op_s[0] = 2'b01; wr_en_s[0] = 1'b1; wr_idx_s[0] = 3'd0; wr_data_s[0] = 32'd5;
    tick();
    check("rot_wr", flat0, 128'h0000000b_0000000c_0000000d_00000005);

    // Out-of-range write and read on the 5-deep instance.
    wr_en_s[1] = 1'b1; wr_idx_s[1] = 3'd7; wr_data_s[1] = 32'h55;
    tick();
    check("wr_oor_err", 128'(err1), 128'd1);
    tick();
    check("wr_oor_err_drop", 128'(err1), 128'd0);
    rd_en_s[1] = 1'b1; rd_idx_s[1] = 3'd6;
    tick();
    check("rd_oor_data", 128'(rd_data1), 128'd0);
    check("rd_oor_vld", 128'(rd_valid1), 128'd1);
    check("rd_oor_err", 128'(err1), 128'd1);

    // Reload ignores a coinciding write.
    wr_en_s[0] = 1'b1; wr_idx_s[0] = 3'd1; wr_data_s[0] = 32'd77;
    tick();
    op_s[0] = 2'b11; wr_en_s[0] = 1'b1; wr_idx_s[0] = 3'd1; wr_data_s[0] = 32'd99;
    tick();
    check("reload_wr", flat0, 128'h0000000a_0000000b_0000000c_0000000d);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      tick();
    end

    // Asynchronous reset in the middle of a burst.
    for (int n = 0; n < 5; n++) begin
      rand_inputs();
      tick();
    end
    rand_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("async_rst_flat0", flat0, 128'h0000000a_0000000b_0000000c_0000000d);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      rand_inputs();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unpacked_array_regbank.md
Name: unpacked_array_regbank

Overview:
- Parametrised register bank held as a 1D unpacked array of DEPTH entries, each WIDTH bits.
- Every entry has a per-index reset constant.
- All entries are exposed as a flattened bus. The bank also supports indexed write, registered indexed read, circular rotate and reload-to-reset-values.
- Serves as the next-generation array fixture for the unpacked-array regression suite, adding sequential state to the constant-array case.

Parameters:
- WIDTH, 32, bits per entry (>=1)
- DEPTH, 4, number of entries (>=2; need not be a power of two)
- IDX_W, $clog2(DEPTH), index width (derived; not overridden)
- RESET_BASE, 13, reset value of entry 0
- RESET_STEP, -1, signed increment per index; entry i resets to (RESET_BASE + i*RESET_STEP) mod 2^WIDTH

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe
- wr_idx  in  IDX_W  write index
- wr_data  in  WIDTH  write data
- op  in  2  00 none, 01 rotate up, 10 rotate down, 11 reload
- rd_en  in  1  read strobe
- rd_idx  in  IDX_W  read index
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  pulses 1 cycle after an accepted rd_en
- err  out  1  pulses 1 cycle after an out-of-range wr_idx or rd_idx
- entries_flat  out  DEPTH*WIDTH  entry i at bits [i*WIDTH +: WIDTH], registered state

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream):
  - entry i <= RESET_BASE + i*RESET_STEP, truncated to WIDTH.
  - rd_data = 0, rd_valid = 0, err = 0.
  - Defaults give entries_flat = 128'h0000000a_0000000b_0000000c_0000000d.
  - Reset asserted mid-operation overrides everything immediately; pending read or write is lost.
- Reset-value arithmetic: computed in at least 64-bit signed, then truncated. Negative results wrap, e.g. BASE=0, STEP=-1, WIDTH=8 gives entry1 = 8'hFF.
- State update per clk edge, in priority order:
  - op=11 reload: all entries take reset values; wr_en is ignored (err still flags a bad wr_idx).
  - op=01 rotate up: entry[i] <= entry[i-1]; entry[0] <= entry[DEPTH-1].
  - op=10 rotate down: entry[i] <= entry[i+1]; entry[DEPTH-1] <= entry[0].
  - Write with wr_en and wr_idx < DEPTH: entry[wr_idx] <= wr_data. When it coincides with a rotate, the write lands in the rotated array and overrides that index only.
  - wr_idx >= DEPTH: no write; err = 1 next cycle.
- Read, latency 1:
  - On rd_en, rd_data <= entry[rd_idx] as it was before the same-edge update (old value); rd_valid = 1 next cycle.
  - Without rd_en, rd_data holds its value and rd_valid = 0.
  - rd_idx >= DEPTH: rd_data <= 0, rd_valid = 1, err = 1.
- err is the OR of the read and write range faults, registered, and lasts 1 cycle.
- entries_flat updates in the cycle after the causing edge, i.e. it directly reflects registered state.
- No handshake back-pressure: every strobe is accepted every cycle.

Decomposition:
- Package arr_regbank_pkg holds:
  - op encoding constants OP_NONE, OP_ROT_UP, OP_ROT_DN, OP_RELOAD;
  - function reset_val(base, step, i, width).
- Optional sub-module arr_regbank_entry: one WIDTH-bit register with reset-value parameter and next-value mux, instantiated DEPTH times via generate. The top owns rotate/write select, read mux and err logic.

Test Plan:
- Reset with defaults -> entries_flat = 128'h0000000a0000000b0000000c0000000d; rd_valid = 0, err = 0.
- rd_en, rd_idx=2 -> next cycle rd_data = 11, rd_valid = 1. Then wr_en idx=2 data=32'hDEAD with rd_en idx=2 on the same edge -> rd_data = 11; a read on the following cycle returns 32'hDEAD.
- op=01 once from reset -> entries {0:10, 1:13, 2:12, 3:11}. Then op=10 twice -> {0:12, 1:11, 2:10, 3:13}.
- op=01 with wr_en idx=0 data=5 on the same edge -> entry0 = 5, entry1 = 13, entry2 = 12, entry3 = 11.
- DEPTH=5: wr_en idx=7 -> no entry change, err = 1 for exactly one cycle. rd_en idx=6 -> rd_data = 0, rd_valid = 1, err = 1.
- After writes, op=11 with wr_en idx=1 data=99 -> all entries back to reset values (entry1 = 12). Then assert rst_n=0 mid-burst -> outputs hit reset values immediately, without waiting for a clock.
